backlight_pwm_gen: RTL and testbench
====================================

// Module: backlight_pwm_gen
// PURPOSE
// - Display-backlight PWM generator. Frame period = 2^PWM_BITS steps, each step t_lsb clocks long.
// - Duty is set by pwm_value; sync_signal (frame/vsync pulse) restarts the period so the dimming is frame-locked.
// - Sits beside the HDMI pass-through pipeline and runs on the 100 MHz reference clock.
// - At 100 MHz: t_lsb=1629 gives ~60 Hz; t_lsb=407 gives ~240 Hz.
// PARAMETERS
// - PWM_BITS     10  duty resolution; steps per period = 2^PWM_BITS
// - TLSB_BITS    12  width of t_lsb (clocks per step)
// - SYNC_STAGES  2   synchronizer flops on sync_signal
// PORTS
// - clk          in   1          100 MHz reference clock; the only clock
// - reset        in   1          asynchronous, active-low reset
// - sync_signal  in   1          frame sync, asynchronous to clk; rising edge restarts period
// - pwm_value    in   PWM_BITS   requested duty (0..1023)
// - t_lsb        in   TLSB_BITS  clocks per duty step; 0 treated as 1
// - pwm_signal   out  1          registered PWM output to backlight driver
// BEHAVIOUR
// - Interface: one clock (clk); reset is asynchronous and active-low.
// - Reset (reset=0), applied asynchronously:
//   - pwm_signal=0, prescaler=0, step=0, duty latch=0.
//   - Synchronizer flops and edge-detect flop=0.
// - Prescaler:
//   - Counts 0..max(t_lsb,1)-1, then wraps to 0.
//   - On wrap, step increments; step wraps 1023->0 (free-running when no sync arrives).
// - Duty latch: loads pwm_value when step wraps to 0 and on every sync restart; pwm_value changes mid-period never glitch the output.
// - Output, registered, computed from latched duty D:
//   - D==0: low always.
//   - D==2^PWM_BITS-1: high always (100%, no gap).
//   - Otherwise: high when step < D. High time = D*t_lsb clocks per period.
// - Sync path:
//   - sync_signal passes through SYNC_STAGES flops, then a rising-edge detect.
//   - The restart strobe is asserted SYNC_STAGES+1 clocks after the input rises.
//   - Restart strobe: prescaler=0, step=0, latch pwm_value. pwm_signal reflects the new period on the next clock.
//   - A held-high sync causes a single restart; a restart mid-period truncates that period.
// - Simultaneous events: a restart coincident with a natural wrap acts as one restart (identical result). Reset dominates all.
// - t_lsb changes: take effect at the next prescaler compare. If the prescaler is >= the new t_lsb, it wraps on the next clock.
// STRUCTURE
// - Shared package holds:
//   - PWM_BITS_DEFAULT=10, TLSB_BITS_DEFAULT=12.
//   - TLSB_60HZ=12'd1629, TLSB_240HZ=12'd407.
// - One sub-module, sync_edge_detect (SYNC_STAGES flops + rise pulse), reusable for other async strobes.
// - Remainder in this module: prescaler, step counter, duty latch, compare, output flop.
// TESTING
// - Reset then free-run: reset=0 mid-run -> pwm_signal=0 immediately.
//   - Then release, t_lsb=4, pwm_value=256, no sync -> period 4096 clks, high 1024 clks.
// - Duty extremes, t_lsb=2:
//   - pwm_value=0 -> never high.
//   - pwm_value=1023 -> constantly high.
//   - pwm_value=1 -> high exactly 2 clks per 2048.
// - Sync restart: mid-period sync rise with pwm_value=512, t_lsb=3.
//   - Restart 3 clks later.
//   - Output high 1536 clks, then low 1536 clks.
// - Glitch-free update: change pwm_value 100->900 mid-period.
//   - Current period keeps high=100*t_lsb; next period uses 900.
// - t_lsb=0 behaves as t_lsb=1: period 1024 clks.
//   - sync held high 5000 clks -> exactly one restart.

Source files
------------

// File: rtl/backlight_pwm_gen_pkg.sv
// Shared constants for the backlight PWM generator: default widths and
// t_lsb presets for common refresh rates at a 100 MHz reference clock.
package backlight_pwm_gen_pkg;

    localparam int unsigned PWM_BITS_DEFAULT  = 10;
    localparam int unsigned TLSB_BITS_DEFAULT = 12;

    localparam logic [11:0] TLSB_60HZ  = 12'd1629;
    localparam logic [11:0] TLSB_240HZ = 12'd407;

endpackage

// File: rtl/backlight_pwm_gen_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector;
// rise pulses for one clock STAGES+1 clocks after async_in goes high.
module sync_edge_detect
    import backlight_pwm_gen_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              rise_q;
    logic              rise_d;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = async_in;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/backlight_pwm_gen.sv
// Frame-locked backlight PWM: prescaler, step counter, duty latch and
// registered compare; a synchronized sync_signal rise restarts the period.
module backlight_pwm_gen
    import backlight_pwm_gen_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEFAULT,
    parameter int unsigned TLSB_BITS   = TLSB_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_signal,
    input  logic [PWM_BITS-1:0]  pwm_value,
    input  logic [TLSB_BITS-1:0] t_lsb,
    output logic                 pwm_signal
);

    localparam logic [PWM_BITS-1:0] STEP_MAX = '1;

    logic                 restart;
    logic [TLSB_BITS-1:0] presc_q;
    logic [TLSB_BITS-1:0] presc_d;
    logic [TLSB_BITS-1:0] presc_last;
    logic                 presc_wrap;
    logic [PWM_BITS-1:0]  step_q;
    logic [PWM_BITS-1:0]  step_d;
    logic [PWM_BITS-1:0]  duty_q;
    logic [PWM_BITS-1:0]  duty_d;
    logic                 pwm_q;
    logic                 pwm_d;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .async_in (sync_signal),
        .rise     (restart)
    );

    always_comb begin
        // >= rather than == so a shrinking t_lsb wraps on the next clock
        presc_last = (t_lsb == '0) ? '0 : t_lsb - TLSB_BITS'(1);
        presc_wrap = (presc_q >= presc_last);

        presc_d = presc_q + TLSB_BITS'(1);
        step_d  = step_q;
        duty_d  = duty_q;

        if (restart) begin
            presc_d = '0;
            step_d  = '0;
            duty_d  = pwm_value;
        end else if (presc_wrap) begin
            presc_d = '0;
            step_d  = step_q + PWM_BITS'(1);
            if (step_q == STEP_MAX) begin
                duty_d = pwm_value;
            end
        end

        // Compare against next-state values so the output flop lines up with step_q
        if (duty_d == '0) begin
            pwm_d = 1'b0;
        end else if (duty_d == STEP_MAX) begin
            pwm_d = 1'b1;
        end else begin
            pwm_d = (step_d < duty_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            step_q  <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_signal = pwm_q;

endmodule

// File: tb/tb_backlight_pwm_gen.sv
// Directed bench for backlight_pwm_gen: period, duty, sync restart latency,
// glitch-free duty update, t_lsb=0 handling and held-high sync.
module tb_backlight_pwm_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sync_signal = 1'b0;
    logic [9:0]  pwm_value = '0;
    logic [11:0] t_lsb = '0;
    logic        pwm_signal;

    int checks = 0;
    int passed = 0;

    backlight_pwm_gen #(
        .PWM_BITS    (10),
        .TLSB_BITS   (12),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sync_signal (sync_signal),
        .pwm_value   (pwm_value),
        .t_lsb       (t_lsb),
        .pwm_signal  (pwm_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Returns at the first negedge sample where the output has just risen
    task automatic wait_rise(input string tag, input int budget);
        logic prev;
        bit   ok;
        prev = pwm_signal;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pwm_signal && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pwm_signal;
        end
        check(tag, int'(ok), 1);
    endtask

    // Called on a rise sample; measures clocks and high clocks up to the next rise
    task automatic measure_period(output int period, output int high);
        logic prev;
        period = 1;
        high   = 1;
        prev   = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (pwm_signal && !prev) break;
            period++;
            high += int'(pwm_signal);
            prev = pwm_signal;
        end
    endtask

    // Length of the run of 'level' starting at the current sample
    task automatic run_len(input logic level, output int len);
        len = 0;
        while (pwm_signal == level && len < 10000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic count_high(input int n, output int high);
        high = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            high += int'(pwm_signal);
        end
    endtask

    initial begin
        int period;
        int high;
        int len;
        int first_rise;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", int'(pwm_signal), 0);

        // Full duty with t_lsb=1, then asynchronous reset mid-run
        pwm_value = 10'd1023;
        t_lsb     = 12'd1;
        reset     = 1'b1;
        repeat (1100) @(negedge clk);
        check("full_before_reset", int'(pwm_signal), 1);
        #2 reset = 1'b0;
        #1 check("async_reset", int'(pwm_signal), 0);

        // Free run: t_lsb=4, pwm_value=256
        @(negedge clk);
        t_lsb     = 12'd4;
        pwm_value = 10'd256;
        reset     = 1'b1;
        wait_rise("freerun_rise", 10000);
        measure_period(period, high);
        check("freerun_period", period, 4096);
        check("freerun_high", high, 1024);

        // Duty extremes at t_lsb=2
        t_lsb     = 12'd2;
        pwm_value = 10'd0;
        repeat (2100) @(negedge clk);
        count_high(2048, high);
        check("duty0_high", high, 0);
        pwm_value = 10'd1023;
        repeat (2100) @(negedge clk);
        count_high(2048, high);
        check("duty1023_high", high, 2048);
        pwm_value = 10'd1;
        wait_rise("duty1_rise", 5000);
        measure_period(period, high);
        check("duty1_period", period, 2048);
        check("duty1_high", high, 2);

        // Sync restart in the low half of a period, t_lsb=3, pwm_value=512
        t_lsb     = 12'd3;
        pwm_value = 10'd512;
        wait_rise("sync_setup_rise", 8000);
        repeat (2036) @(negedge clk);
        sync_signal = 1'b1;
        repeat (3) @(negedge clk);
        check("sync_latency_pre", int'(pwm_signal), 0);
        @(negedge clk);
        check("sync_latency_post", int'(pwm_signal), 1);
        run_len(1'b1, len);
        check("sync_high_run", len, 1536);
        sync_signal = 1'b0;
        run_len(1'b0, len);
        check("sync_low_run", len, 1536);

        // Glitch-free duty change: 100 latched, 900 arrives mid-period
        pwm_value = 10'd100;
        run_len(1'b1, len);
        run_len(1'b0, len);
        pwm_value = 10'd900;
        run_len(1'b1, len);
        check("glitch_cur_high", len, 300);
        run_len(1'b0, len);
        check("glitch_cur_low", len, 2772);
        run_len(1'b1, len);
        check("glitch_next_high", len, 2700);

        // t_lsb=0 acts as 1
        pwm_value = 10'd512;
        t_lsb     = 12'd0;
        wait_rise("tlsb0_rise", 5000);
        measure_period(period, high);
        check("tlsb0_period", period, 1024);
        check("tlsb0_high", high, 512);

        // Held-high sync: single restart 4 samples after raising, then free run
        repeat (699) @(negedge clk);
        sync_signal = 1'b1;
        prev        = pwm_signal;
        first_rise  = 0;
        high        = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (pwm_signal && !prev && first_rise == 0) first_rise = i;
            high += int'(pwm_signal);
            prev = pwm_signal;
        end
        sync_signal = 1'b0;
        check("held_sync_first_rise", first_rise, 4);
        check("held_sync_high", high, 2560);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
